// File: rtl/dsram_ctrl.sv
// Data-memory access stage: one AXI4-Lite read or write per memory instruction,
// with load alignment/extension and a valid/ready hand-off to writeback.
module dsram_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = 8,
    parameter int INST_W = 3,
    parameter int OP_W   = 4,
    parameter logic [INST_W-1:0] INST_LOAD  = INST_W'(1),
    parameter logic [INST_W-1:0] INST_STORE = INST_W'(2),
    parameter logic [OP_W-1:0]   LSU_OP_LB  = OP_W'(1),
    parameter logic [OP_W-1:0]   LSU_OP_LH  = OP_W'(2),
    parameter logic [OP_W-1:0]   LSU_OP_LW  = OP_W'(3),
    parameter logic [OP_W-1:0]   LSU_OP_LBU = OP_W'(4),
    parameter logic [OP_W-1:0]   LSU_OP_LHU = OP_W'(5)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_pre_i,
    output logic              ready_pre_o,
    input  logic [INST_W-1:0] inst_type_i,
    input  logic [OP_W-1:0]   lsu_op_i,
    input  logic [ADDR_W-1:0] araddr_i,
    input  logic [ADDR_W-1:0] roff_i,
    input  logic [ADDR_W-1:0] awaddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [STRB_W-1:0] wstrb_i,
    output logic              arvalid_o,
    input  logic              arready_i,
    output logic [ADDR_W-1:0] araddr_o,
    input  logic              rvalid_i,
    output logic              rready_o,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [STRB_W-1:0] wstrb_o,
    input  logic              bvalid_i,
    output logic              bready_o,
    input  logic [1:0]        bresp_i,
    output logic              valid_post_o,
    input  logic              ready_post_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              lsu_err_o
);

    localparam int IDX_W = $clog2(STRB_W);

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_t;

    state_t          state_reg;
    logic [OP_W-1:0] op_reg;
    logic [1:0]      off_reg;

    logic [DATA_W-1:0] ld_shift;
    logic [DATA_W-1:0] ld_ext;
    logic              ld_bad;
    logic [IDX_W-1:0]  low_idx;
    logic              unused_ok;

    assign ready_pre_o = (state_reg == IDLE) && rst;

    // Word-aligned bus addresses drop the byte offset; only roff[1:0] matters.
    assign unused_ok = ^{araddr_i[1:0], awaddr_i[1:0], roff_i[ADDR_W-1:2]};

    always_comb begin
        ld_shift = rdata_i >> {off_reg, 3'b000};
        ld_ext   = '0;
        ld_bad   = 1'b0;
        case (op_reg)
            LSU_OP_LB:  ld_ext = {{(DATA_W-8){ld_shift[7]}}, ld_shift[7:0]};
            LSU_OP_LBU: ld_ext = {{(DATA_W-8){1'b0}}, ld_shift[7:0]};
            LSU_OP_LH, LSU_OP_LHU: begin
                if (off_reg == 2'd3)
                    ld_bad = 1'b1;
                else
                    ld_ext = {{(DATA_W-16){(op_reg == LSU_OP_LH) && ld_shift[15]}},
                              ld_shift[15:0]};
            end
            LSU_OP_LW: begin
                if (off_reg != 2'd0)
                    ld_bad = 1'b1;
                else
                    ld_ext = ld_shift;
            end
            default: ld_bad = 1'b1;
        endcase
    end

    // Store data arrives unshifted; the lowest enabled lane says where it goes.
    always_comb begin
        low_idx = '0;
        for (int i = STRB_W - 1; i >= 0; i--) begin
            if (wstrb_i[i])
                low_idx = i[IDX_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            op_reg       <= '0;
            off_reg      <= '0;
            arvalid_o    <= 1'b0;
            rready_o     <= 1'b0;
            awvalid_o    <= 1'b0;
            wvalid_o     <= 1'b0;
            bready_o     <= 1'b0;
            valid_post_o <= 1'b0;
            araddr_o     <= '0;
            awaddr_o     <= '0;
            wdata_o      <= '0;
            wstrb_o      <= '0;
            rdata_o      <= '0;
            lsu_err_o    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (valid_pre_i) begin
                        op_reg  <= lsu_op_i;
                        off_reg <= roff_i[1:0];
                        if (inst_type_i == INST_LOAD) begin
                            araddr_o  <= {araddr_i[ADDR_W-1:2], 2'b00};
                            arvalid_o <= 1'b1;
                            state_reg <= RADDR;
                        end else if ((inst_type_i == INST_STORE) && (wstrb_i != '0)) begin
                            awaddr_o  <= {awaddr_i[ADDR_W-1:2], 2'b00};
                            wdata_o   <= wdata_i << {low_idx, 3'b000};
                            wstrb_o   <= wstrb_i;
                            awvalid_o <= 1'b1;
                            wvalid_o  <= 1'b1;
                            state_reg <= WREQ;
                        end else begin
                            // Empty-strobe stores are flagged without touching the bus.
                            rdata_o      <= '0;
                            lsu_err_o    <= (inst_type_i == INST_STORE);
                            valid_post_o <= 1'b1;
                            state_reg    <= DONE;
                        end
                    end
                end
                RADDR: begin
                    if (arready_i) begin
                        arvalid_o <= 1'b0;
                        rready_o  <= 1'b1;
                        state_reg <= RDATA;
                    end
                end
                RDATA: begin
                    if (rvalid_i) begin
                        rready_o     <= 1'b0;
                        rdata_o      <= ld_ext;
                        lsu_err_o    <= ld_bad || (rresp_i != 2'b00);
                        valid_post_o <= 1'b1;
                        state_reg    <= DONE;
                    end
                end
                WREQ: begin
                    if (awvalid_o && awready_i)
                        awvalid_o <= 1'b0;
                    if (wvalid_o && wready_i)
                        wvalid_o <= 1'b0;
                    // Each channel is finished once its valid is gone or handshaking now.
                    if ((!awvalid_o || awready_i) && (!wvalid_o || wready_i)) begin
                        bready_o  <= 1'b1;
                        state_reg <= WRESP;
                    end
                end
                WRESP: begin
                    if (bvalid_i) begin
                        bready_o     <= 1'b0;
                        rdata_o      <= '0;
                        lsu_err_o    <= (bresp_i != 2'b00);
                        valid_post_o <= 1'b1;
                        state_reg    <= DONE;
                    end
                end
                DONE: begin
                    if (ready_post_i) begin
                        valid_post_o <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsram_ctrl.sv
// Randomised scoreboard bench for dsram_ctrl: driver, AXI slave model and result
// monitor run as separate processes sharing expectation queues.
module tb_dsram_ctrl;

    localparam logic [2:0] I_ALU = 3'd0, I_LOAD = 3'd1, I_STORE = 3'd2, I_CSR = 3'd3;
    localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4,
                           OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

    logic        clk = 1'b0, rst = 1'b0;
    logic        valid_pre_i = 1'b0, ready_pre_o;
    logic [2:0]  inst_type_i = '0;
    logic [3:0]  lsu_op_i = '0;
    logic [31:0] araddr_i = '0, roff_i = '0, awaddr_i = '0, wdata_i = '0;
    logic [7:0]  wstrb_i = '0;
    logic        arvalid_o, arready_i = 1'b0;
    logic [31:0] araddr_o;
    logic        rvalid_i = 1'b0, rready_o;
    logic [31:0] rdata_i = '0;
    logic [1:0]  rresp_i = '0;
    logic        awvalid_o, awready_i = 1'b0;
    logic [31:0] awaddr_o;
    logic        wvalid_o, wready_i = 1'b0;
    logic [31:0] wdata_o;
    logic [7:0]  wstrb_o;
    logic        bvalid_i = 1'b0, bready_o;
    logic [1:0]  bresp_i = '0;
    logic        valid_post_o, ready_post_i = 1'b0;
    logic [31:0] rdata_o;
    logic        lsu_err_o;

    dsram_ctrl dut (
        .clk(clk), .rst(rst),
        .valid_pre_i(valid_pre_i), .ready_pre_o(ready_pre_o),
        .inst_type_i(inst_type_i), .lsu_op_i(lsu_op_i),
        .araddr_i(araddr_i), .roff_i(roff_i), .awaddr_i(awaddr_i),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
        .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i),
        .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
        .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i),
        .valid_post_o(valid_post_o), .ready_post_i(ready_post_i),
        .rdata_o(rdata_o), .lsu_err_o(lsu_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;   // 0 = latency not checked
    } res_t;
    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
    } rsp_t;

    res_t        exp_q[$];
    logic [31:0] ar_q[$];
    rsp_t        r_q[$];
    logic [31:0] aw_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  ws_q[$];
    logic [1:0]  b_q[$];

    int n_checks = 0, n_pass = 0;
    int mode = 1;          // 0 random slave, 1 zero-wait, 2 AW before W, 3 W before AW
    bit slave_en = 1'b1;
    bit hold_req = 1'b0;
    int txn_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference load semantics written as plain integer arithmetic.
    function automatic void load_model(input logic [3:0] op, input logic [31:0] rd, input int off,
                                       input logic [1:0] resp, output logic [31:0] res,
                                       output logic err);
        longint unsigned s;
        longint v;
        s   = {32'h0, rd} >> (8 * off);
        err = (resp != 2'b00);
        res = '0;
        if (op == OP_LB || op == OP_LBU) begin
            v = longint'(s % 256);
            if (op == OP_LB && v >= 128) v -= 256;
            res = 32'(v);
        end else if (op == OP_LH || op == OP_LHU) begin
            if (off == 3) err = 1'b1;
            else begin
                v = longint'(s % 65536);
                if (op == OP_LH && v >= 32768) v -= 65536;
                res = 32'(v);
            end
        end else begin
            if (off != 0) err = 1'b1;
            else res = rd;
        end
    endfunction

    // Called at a negedge; returns at the negedge after acceptance with valid_pre low.
    task automatic issue(input logic [2:0] it, input logic [3:0] op, input logic [31:0] addr,
                         input int off, input logic [31:0] wd, input logic [7:0] strb,
                         input logic [31:0] rd, input logic [1:0] resp);
        res_t e;
        int   low;
        int   t;
        valid_pre_i = 1'b1;
        inst_type_i = it;
        lsu_op_i    = op;
        araddr_i    = addr;
        awaddr_i    = addr;
        roff_i      = 32'(off);
        wdata_i     = wd;
        wstrb_i     = strb;
        t = 0;
        while (!ready_pre_o && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!ready_pre_o) begin
            fail_now("accept_timeout");
            valid_pre_i = 1'b0;
            return;
        end
        e.lat = 0;
        e.acc = cyc;
        if (it == I_LOAD) begin
            ar_q.push_back(addr & 32'hFFFF_FFFC);
            r_q.push_back('{rd, resp});
            load_model(op, rd, off, resp, e.rdata, e.err);
            if (mode == 1) e.lat = 3;
        end else if (it == I_STORE && strb != 8'h00) begin
            low = 0;
            while (strb[low] == 1'b0) low++;
            aw_q.push_back(addr & 32'hFFFF_FFFC);
            wd_q.push_back(wd << (8 * low));
            ws_q.push_back(strb);
            b_q.push_back(resp);
            e.rdata = '0;
            e.err   = (resp != 2'b00);
            if (mode == 1) e.lat = 3;
        end else begin
            e.rdata = '0;
            e.err   = (it == I_STORE);
            e.lat   = 1;
        end
        exp_q.push_back(e);
        @(negedge clk);
        valid_pre_i = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || valid_post_o) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) fail_now("drain_timeout");
        @(negedge clk);
    endtask

    // AXI slave model
    initial begin
        rsp_t       cr;
        logic [1:0] cb;
        int  r_dly = 0, b_dly = 0;
        bit  r_pend = 0, b_pend = 0, r_hs = 0, b_hs = 0, aw_done = 0, w_done = 0;
        forever begin
            @(negedge clk);
            if (!slave_en) continue;
            if (!rst) begin
                r_pend = 0; b_pend = 0; r_hs = 0; b_hs = 0; aw_done = 0; w_done = 0;
                arready_i = 0; rvalid_i = 0; awready_i = 0; wready_i = 0; bvalid_i = 0;
                continue;
            end
            if (r_hs) begin rvalid_i = 1'b0; r_hs = 0; end
            if (!rvalid_i) rdata_i = $urandom;
            if (r_pend) begin
                if (r_dly == 0) begin
                    rvalid_i = 1'b1; rdata_i = cr.d; rresp_i = cr.r; r_pend = 0;
                end else r_dly--;
            end
            arready_i = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (arvalid_o && arready_i) begin
                if (ar_q.size() == 0) fail_now("unexpected_ar");
                else begin
                    check("araddr", araddr_o, ar_q.pop_front());
                    cr = r_q.pop_front();
                    r_pend = 1;
                    r_dly = (mode == 0) ? int'($urandom_range(0, 2)) : 0;
                end
            end
            r_hs = rvalid_i && rready_o;

            if (b_hs) begin bvalid_i = 1'b0; b_hs = 0; end
            if (b_pend) begin
                if (b_dly == 0) begin bvalid_i = 1'b1; bresp_i = cb; b_pend = 0; end
                else b_dly--;
            end
            case (mode)
                0: begin awready_i = 1'($urandom_range(0, 1)); wready_i = 1'($urandom_range(0, 1)); end
                2: begin awready_i = 1'b1; wready_i = aw_done; end
                3: begin awready_i = w_done; wready_i = 1'b1; end
                default: begin awready_i = 1'b1; wready_i = 1'b1; end
            endcase
            if (awvalid_o && awready_i) begin
                if (aw_q.size() == 0) fail_now("unexpected_aw");
                else check("awaddr", awaddr_o, aw_q.pop_front());
                aw_done = 1;
            end
            if (wvalid_o && wready_i) begin
                if (wd_q.size() == 0) fail_now("unexpected_w");
                else begin
                    check("wdata", wdata_o, wd_q.pop_front());
                    check("wstrb", 32'(wstrb_o), 32'(ws_q.pop_front()));
                end
                w_done = 1;
            end
            if (aw_done && w_done) begin
                aw_done = 0; w_done = 0;
                cb = (b_q.size() != 0) ? b_q.pop_front() : 2'b00;
                b_pend = 1;
                b_dly = (mode == 0) ? int'($urandom_range(0, 2)) : 0;
            end
            b_hs = bvalid_i && bready_o;
        end
    end

    // Result monitor / scoreboard
    initial begin
        res_t        e;
        bit          shown = 0, hs_prev = 0;
        logic [31:0] held_d = '0;
        logic        held_e = 1'b0;
        int          idle = 0, hold_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                shown = 0; hs_prev = 0; idle = 0; ready_post_i = 1'b0;
                continue;
            end
            if (hs_prev) begin
                check("b2b_ready_pre", 32'(ready_pre_o), 32'd1);
                hs_prev = 0;
            end
            if (valid_post_o) begin
                check("busy_ready_pre", 32'(ready_pre_o), 32'd0);
                if (!shown) begin
                    shown = 1; idle = 0;
                    if (exp_q.size() == 0) fail_now("unexpected_result");
                    else begin
                        e = exp_q.pop_front();
                        check("rdata_o", rdata_o, e.rdata);
                        check("lsu_err_o", 32'(lsu_err_o), 32'(e.err));
                        if (e.lat != 0) check("latency", 32'(cyc - e.acc), 32'(e.lat));
                        txn_no++;
                        $display("txn %0d: rdata_o=%h lsu_err_o=%0d latency=%0d",
                                 txn_no, rdata_o, lsu_err_o, cyc - e.acc);
                    end
                    held_d = rdata_o;
                    held_e = lsu_err_o;
                    hold_cnt = hold_req ? 5 : 0;
                    hold_req = 1'b0;
                end else begin
                    check("hold_rdata", rdata_o, held_d);
                    check("hold_err", 32'(lsu_err_o), 32'(held_e));
                end
                if (hold_cnt > 0) begin
                    ready_post_i = 1'b0;
                    hold_cnt--;
                end else ready_post_i = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
                if (ready_post_i) begin shown = 0; hs_prev = 1; end
            end else begin
                ready_post_i = 1'($urandom_range(0, 1));
                if (exp_q.size() != 0) begin
                    idle++;
                    if (idle > 300) begin
                        fail_now("result_timeout");
                        void'(exp_q.pop_front());
                        idle = 0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        logic [3:0] lops[5] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        logic [3:0] sops[3] = '{OP_SB, OP_SH, OP_SW};
        logic [2:0] it;
        logic [3:0] op;
        logic [7:0] strb;
        logic [1:0] resp;
        int k;
        int t;

        repeat (3) @(negedge clk);
        check("rst_ready_pre", 32'(ready_pre_o), 32'd0);
        check("rst_valids", 32'({arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, valid_post_o}), 32'd0);
        check("rst_araddr", araddr_o, 32'd0);
        check("rst_awaddr", awaddr_o, 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_wstrb", 32'(wstrb_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_err", 32'(lsu_err_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_ready_pre", 32'(ready_pre_o), 32'd1);

        // Directed, zero-wait slave
        mode = 1;
        issue(I_LOAD, OP_LBU, 32'h8000_0102, 2, 32'h0, 8'h0, 32'hAABB_CCDD, 2'b00);
        issue(I_LOAD, OP_LH,  32'h8000_0202, 2, 32'h0, 8'h0, 32'h8001_1234, 2'b00);
        issue(I_LOAD, OP_LW,  32'h8000_0301, 1, 32'h0, 8'h0, 32'h1234_5678, 2'b00);
        issue(I_LOAD, OP_LHU, 32'h8000_0403, 3, 32'h0, 8'h0, 32'hFFFF_FFFF, 2'b00);
        issue(I_LOAD, OP_LB,  32'h8000_0500, 0, 32'h0, 8'h0, 32'h0000_0080, 2'b11);
        issue(I_STORE, OP_SB, 32'h8000_0003, 0, 32'h0000_00EE, 8'h08, 32'h0, 2'b00);
        issue(I_STORE, OP_SW, 32'h8000_0010, 0, 32'hDEAD_BEEF, 8'h0F, 32'h0, 2'b10);
        issue(I_STORE, OP_SH, 32'h8000_0020, 0, 32'h0000_1234, 8'h00, 32'h0, 2'b00);
        issue(I_ALU, OP_LW, 32'h0, 0, 32'h0, 8'h0, 32'h0, 2'b00);
        drain();
        mode = 2;
        issue(I_STORE, OP_SB, 32'h8000_0003, 0, 32'h0000_00EE, 8'h08, 32'h0, 2'b00);
        drain();
        mode = 3;
        issue(I_STORE, OP_SH, 32'h8000_0006, 0, 32'h0000_ABCD, 8'h0C, 32'h0, 2'b01);
        drain();

        // Held result followed by a back-to-back request
        mode = 1;
        hold_req = 1'b1;
        issue(I_LOAD, OP_LB, 32'h8000_0601, 1, 32'h0, 8'h0, 32'h0000_F100, 2'b00);
        issue(I_CSR, OP_LW, 32'h0, 0, 32'h0, 8'h0, 32'h0, 2'b00);
        drain();

        // Randomised traffic with a randomly stalling slave and writeback
        mode = 0;
        repeat (80) begin
            k = int'($urandom_range(0, 7));
            it = (k < 3) ? I_LOAD : (k < 6) ? I_STORE : (k == 6) ? I_ALU : I_CSR;
            op = (it == I_STORE) ? sops[$urandom_range(0, 2)] : lops[$urandom_range(0, 4)];
            strb = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 15));
            resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            issue(it, op, $urandom, int'($urandom_range(0, 3)), $urandom, strb, $urandom, resp);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        // Reset while waiting in the read-data phase
        slave_en = 1'b0;
        mode = 1;
        arready_i = 1'b0; rvalid_i = 1'b0; awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0;
        issue(I_LOAD, OP_LW, 32'h0000_0100, 0, 32'h0, 8'h0, 32'h5555_5555, 2'b00);
        check("rst_test_araddr", araddr_o, 32'h0000_0100);
        arready_i = 1'b1;
        @(negedge clk);
        arready_i = 1'b0;
        t = 0;
        while (!rready_o && t < 10) begin @(negedge clk); t++; end
        check("rst_test_rready", 32'(rready_o), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        exp_q.delete(); ar_q.delete(); r_q.delete();
        check("midrst_valids", 32'({arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, valid_post_o}), 32'd0);
        check("midrst_ready_pre", 32'(ready_pre_o), 32'd0);
        check("midrst_araddr", araddr_o, 32'd0);
        rst = 1'b1;
        #1;
        check("postrst_ready_pre", 32'(ready_pre_o), 32'd1);
        @(negedge clk);
        rvalid_i = 1'b1;
        rdata_i  = 32'hCAFE_F00D;
        repeat (3) begin
            @(negedge clk);
            check("late_rvalid_ignored", 32'({valid_post_o, rready_o}), 32'd0);
        end
        rvalid_i = 1'b0;
        issue(I_ALU, OP_LW, 32'h0, 0, 32'h0, 8'h0, 32'h0, 2'b00);
        drain();

        check("queues_empty", 32'(exp_q.size() + ar_q.size() + r_q.size() + aw_q.size()
                                  + wd_q.size() + ws_q.size() + b_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
